// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: NUM_NEURONS saturating MAC lanes share one
// pixel stream, then requantise/activate. Define DENSE_BIAS_EN for per-lane bias.
module dense_layer_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int SHIFT       = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_WIDTH-1:0]      input_pixel,
  output logic [ADDR_WIDTH-1:0]             weight_addr,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] weights,
`ifdef DENSE_BIAS_EN
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] bias,
`endif
  input  logic [1:0]                        activation_type,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
  output logic                              busy,
  output logic                              done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int LW = NUM_NEURONS * DW;

  localparam logic signed [ACC_WIDTH:0] AMAX =
    {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] AMIN =
    {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] DMAX =
    {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DMIN =
    {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, ACCUM, ACT, OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [ACC_WIDTH-1:0] acc_q  [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] acc_d  [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] init_d [NUM_NEURONS];
  logic [CW-1:0]               count_q;
  logic [LW-1:0]               out_q;
  logic [LW-1:0]               act_d;
  logic                        accept;
  logic                        last;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [ACC_WIDTH:0] v
  );
    if (v > AMAX)      sat_acc = AMAX[ACC_WIDTH-1:0];
    else if (v < AMIN) sat_acc = AMIN[ACC_WIDTH-1:0];
    else               sat_acc = v[ACC_WIDTH-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_data(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (v > DMAX)      sat_data = DMAX[DW-1:0];
    else if (v < DMIN) sat_data = DMIN[DW-1:0];
    else               sat_data = v[DW-1:0];
  endfunction

  assign accept      = in_valid && in_ready;
  assign last        = accept && (count_q == CW'(NUM_INPUTS - 1));
  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == OUT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == OUT) && out_ready;
  assign out_data    = out_q;
  assign weight_addr = (state_q == ACCUM) ?
                       count_q[ADDR_WIDTH-1:0] : '0;

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
    logic signed [DW-1:0]        w_k;
    logic signed [2*DW-1:0]      prod;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [DW-1:0]        q;
    logic signed [DW-1:0]        a;

    assign w_k     = weights[k*DW +: DW];
    assign prod    = input_pixel * w_k;
    assign sum     = (ACC_WIDTH+1)'(acc_q[k]) + (ACC_WIDTH+1)'(prod);
    assign acc_d[k] = sat_acc(sum);
`ifdef DENSE_BIAS_EN
    assign init_d[k] =
      ACC_WIDTH'($signed(bias[k*DW +: DW])) <<< SHIFT;
`else
    assign init_d[k] = '0;
`endif
    assign shifted = acc_q[k] >>> SHIFT;
    assign q       = sat_data(shifted);

    // Activation applied to the requantised lane value
    always_comb begin
      a = q;
      case (activation_type)
        2'b01:   if (q < 0) a = '0;
        2'b10:   if (q < 0) a = q >>> 3;
        default: a = q;
      endcase
    end

    assign act_d[k*DW +: DW] = a;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: start restarts from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ACCUM;
      ACCUM: if (start) state_d = ACCUM;
             else if (last) state_d = ACT;
      ACT:   if (start) state_d = ACCUM;
             else state_d = OUT;
      OUT:   if (start) state_d = ACCUM;
             else if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulators, pixel count and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) acc_q[k] <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      if (start) begin
        for (int k = 0; k < NUM_NEURONS; k++) acc_q[k] <= init_d[k];
        count_q <= '0;
      end else if (accept) begin
        for (int k = 0; k < NUM_NEURONS; k++) acc_q[k] <= acc_d[k];
        count_q <= count_q + 1'b1;
      end
      if (state_q == ACT && !start) out_q <= act_d;
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: directed corner cases plus random passes
// checked against an integer reference model.
module tb_dense_layer_engine;

  localparam int DW = 8;
  localparam int NN = 4;
  localparam int AW = 8;
  localparam int SH = 4;
  localparam int LW = NN * DW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start4 = 1'b0, start64 = 1'b0;
  logic iv4 = 1'b0, iv64 = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DW-1:0] pixel = '0;
  logic [1:0] act = 2'b00;
  logic [LW-1:0] wtab [64];
  logic [LW-1:0] bias_v = '0;
  logic [LW-1:0] w4, w64;
  logic ir4, ir64, ov4, ov64;
  logic busy4, busy64, done4, done64;
  logic [AW-1:0] wa4, wa64;
  logic [LW-1:0] od4, od64;
  logic signed [DW-1:0] pix [64];
  int vectors = 0;
  int miscompares = 0;
  logic [LW-1:0] e;

  always #5 clk = ~clk;

  assign w4  = wtab[wa4[5:0]];
  assign w64 = wtab[wa64[5:0]];

  dense_layer_engine #(
    .NUM_INPUTS(4)
  ) u4 (
    .clk(clk), .reset_n(reset_n), .start(start4),
    .in_valid(iv4), .in_ready(ir4), .input_pixel(pixel),
    .weight_addr(wa4), .weights(w4),
`ifdef DENSE_BIAS_EN
    .bias(bias_v),
`endif
    .activation_type(act), .out_valid(ov4),
    .out_ready(out_ready), .out_data(od4),
    .busy(busy4), .done(done4)
  );

  dense_layer_engine #(
    .NUM_INPUTS(64)
  ) u64 (
    .clk(clk), .reset_n(reset_n), .start(start64),
    .in_valid(iv64), .in_ready(ir64), .input_pixel(pixel),
    .weight_addr(wa64), .weights(w64),
`ifdef DENSE_BIAS_EN
    .bias(bias_v),
`endif
    .activation_type(act), .out_valid(ov64),
    .out_ready(out_ready), .out_data(od64),
    .busy(busy64), .done(done64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_bias();
`ifdef DENSE_BIAS_EN
    return LW'($urandom);
`else
    return '0;
`endif
  endfunction

  // Plain integer arithmetic: dot product with clamp, floor shift, clamp, activate
  function automatic logic [LW-1:0] model(input int n, input logic [1:0] at);
    logic [LW-1:0] r;
    longint acc, q;
    r = '0;
    for (int k = 0; k < NN; k++) begin
      acc = longint'($signed(bias_v[k*DW +: DW])) * 16;
      for (int i = 0; i < n; i++) begin
        acc = acc + longint'(pix[i]) *
              longint'($signed(wtab[i][k*DW +: DW]));
        if (acc > 524287) acc = 524287;
        if (acc < -524288) acc = -524288;
      end
      q = acc >>> SH;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      if (at == 2'b01 && q < 0) q = 0;
      if (at == 2'b10 && q < 0) q = q >>> 3;
      r[k*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  task automatic do_start();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  // Feed 4 pixels from ACCUM, then check ACT gap, output, stall and handshake
  task automatic body(input string tag, input logic [1:0] at,
                      input bit gaps, input int stall);
    logic [LW-1:0] exp;
    act = at;
    chk({tag, " in_ready"}, LW'(ir4), LW'(1));
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        iv4 = 1'b0;
        tick();
        chk({tag, " addr_hold"}, LW'(wa4), LW'(i));
      end
      pixel = pix[i];
      iv4 = 1'b1;
      chk({tag, " addr"}, LW'(wa4), LW'(i));
      tick();
      iv4 = 1'b0;
    end
    chk({tag, " act_gap"}, LW'({ov4, ir4}), LW'(0));
    tick();
    exp = model(4, at);
    chk({tag, " out_valid"}, LW'(ov4), LW'(1));
    chk({tag, " out_data"}, od4, exp);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      #1;
      chk({tag, " stall_done"}, LW'(done4), LW'(0));
      tick();
      chk({tag, " stall_data"}, od4, exp);
      chk({tag, " stall_valid"}, LW'(ov4), LW'(1));
    end
    out_ready = 1'b1;
    #1;
    chk({tag, " done"}, LW'(done4), LW'(1));
    tick();
    out_ready = 1'b0;
    #1;
    chk({tag, " idle"}, LW'({ov4, busy4, done4}), LW'(0));
  endtask

  task automatic set_w(input logic signed [DW-1:0] w0,
                       input logic signed [DW-1:0] w1,
                       input logic signed [DW-1:0] w2,
                       input logic signed [DW-1:0] w3);
    for (int i = 0; i < 64; i++) wtab[i] = {w3, w2, w1, w0};
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      wtab[i] = '0;
      pix[i] = '0;
    end
    tick();
    chk("reset_outs", LW'({ir4, ov4, busy4, done4, wa4}), LW'(0));
    chk("reset_data", od4, '0);
    reset_n = 1'b1;
    tick();
    iv4 = 1'b1;
    tick();
    chk("idle_ignores_valid", LW'({ir4, busy4}), LW'(0));
    iv4 = 1'b0;

    // Identity: lane0 w=2 -> 5, lane1 w=0 -> 0, lane2 w=-3 -> -8
    set_w(8'sd2, 8'sd0, -8'sd3, 8'sd1);
    for (int i = 0; i < 4; i++) pix[i] = 8'sd10;
    do_start();
    body("ident", 2'b00, 1'b0, 0);
    chk("ident_lane0", LW'(od4[7:0]), LW'(8'd5));
    chk("ident_lane1", LW'(od4[15:8]), LW'(8'd0));
    chk("ident_lane2", LW'(od4[23:16]), LW'(8'hf8));
    do_start();
    body("relu", 2'b01, 1'b0, 0);
    chk("relu_lane2", LW'(od4[23:16]), LW'(8'd0));
    do_start();
    body("leaky", 2'b10, 1'b1, 0);
    chk("leaky_lane2", LW'(od4[23:16]), LW'(8'hff));
    do_start();
    body("resv", 2'b11, 1'b0, 1);
    chk("resv_lane2", LW'(od4[23:16]), LW'(8'hf8));

`ifdef DENSE_BIAS_EN
    bias_v = {4{8'sd3}};
    do_start();
    body("bias", 2'b00, 1'b0, 0);
    chk("bias_lane0", LW'(od4[7:0]), LW'(8'd8));
    bias_v = '0;
`endif

    // Output saturation both ways
    for (int i = 0; i < 4; i++) pix[i] = 8'sd127;
    set_w(8'sd127, 8'sd127, -8'sd128, -8'sd128);
    do_start();
    body("sat", 2'b00, 1'b0, 0);
    chk("sat_vals", od4, 32'h8080_7f7f);

    // Stalled input and stalled output
    set_w(8'sd2, -8'sd5, 8'sd7, -8'sd1);
    for (int i = 0; i < 4; i++) pix[i] = DW'($urandom);
    do_start();
    body("stall", 2'b00, 1'b1, 5);

    // Abort mid-ACCUM; start wins over a coincident pixel
    set_w(8'sd2, 8'sd0, -8'sd3, 8'sd1);
    for (int i = 0; i < 4; i++) pix[i] = 8'sd10;
    do_start();
    pixel = 8'sd50;
    iv4 = 1'b1;
    tick();
    tick();
    chk("pre_abort_addr", LW'(wa4), LW'(2));
    pixel = 8'sd99;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    iv4 = 1'b0;
    chk("abort_addr", LW'(wa4), LW'(0));
    body("abort", 2'b00, 1'b0, 0);
    chk("abort_lane0", LW'(od4[7:0]), LW'(8'd5));

    // Abort in OUT without handshake, then start with handshake
    do_start();
    iv4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pixel = 8'sd10;
      tick();
    end
    iv4 = 1'b0;
    tick();
    chk("out_reached", LW'(ov4), LW'(1));
    start4 = 1'b1;
    #1;
    chk("abort_no_done", LW'(done4), LW'(0));
    tick();
    start4 = 1'b0;
    chk("abort_out", LW'({ov4, ir4}), LW'(1));
    iv4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pixel = 8'sd10;
      tick();
    end
    iv4 = 1'b0;
    tick();
    start4 = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("start_hs_done", LW'(done4), LW'(1));
    tick();
    start4 = 1'b0;
    out_ready = 1'b0;
    chk("start_hs_accum", LW'({ov4, busy4, ir4}), LW'(3));
    body("after_hs", 2'b00, 1'b0, 0);

    // Reset mid-ACCUM
    do_start();
    iv4 = 1'b1;
    tick();
    tick();
    iv4 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_outs", LW'({ir4, ov4, busy4, done4, wa4}), LW'(0));
    chk("rst_data", od4, '0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_idle", LW'(busy4), LW'(0));

    // Random passes
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4; i++) begin
        pix[i] = DW'($urandom);
        wtab[i] = LW'($urandom);
      end
      bias_v = rand_bias();
      do_start();
      body("rand", 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    bias_v = '0;

    // 64 inputs of 127*127 must clamp the accumulator, not wrap
    set_w(8'sd127, 8'sd127, 8'sd127, 8'sd127);
    for (int i = 0; i < 64; i++) pix[i] = 8'sd127;
    act = 2'b00;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    pixel = 8'sd127;
    iv64 = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    iv64 = 1'b0;
    chk("acc64_act", LW'(ov64), LW'(0));
    tick();
    e = model(64, 2'b00);
    chk("acc64_valid", LW'(ov64), LW'(1));
    chk("acc64_model", od64, e);
    chk("acc64_clamp", od64, {4{8'h7f}});
    out_ready = 1'b1;
    #1;
    chk("acc64_done", LW'(done64), LW'(1));
    tick();
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
